// File: rtl/can_size_sequencer.sv
// Per-frame sequencer for one sizeDetect instance: synchronises CAN RX, detects bus idle,
// hard-syncs a bit timer on SOF, drives the detector and latches the resulting DLC.
module can_size_sequencer #(
   parameter int unsigned CLKS_PER_BIT = 50,
   parameter int unsigned SAMPLE_PT    = 35,
   parameter int unsigned IDLE_BITS    = 11,
   parameter int unsigned TIMEOUT_BITS = 40
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ctrl_en,
   input  logic       triple_sample,
   input  logic       rx_in,
   output logic       sd_din,
   output logic       sd_sample_pulse,
   output logic       sd_rate_sel,
   output logic       sd_enable,
   output logic       sd_resetN,
   input  logic       sd_complete,
   input  logic [3:0] sd_msg_size,
   output logic       armed,
   output logic       busy,
   output logic       size_valid,
   output logic [3:0] msg_size,
   output logic [3:0] data_bytes,
   output logic       timeout_err
);

   localparam int unsigned IDLE_W    = $clog2(IDLE_BITS*CLKS_PER_BIT+1);
   localparam int unsigned CNT_W     = $clog2(CLKS_PER_BIT);
   localparam int unsigned BIT_W     = $clog2(TIMEOUT_BITS+1);
   localparam int unsigned IDLE_LAST = IDLE_BITS*CLKS_PER_BIT-1;

   typedef enum logic [2:0] {
      S_REARM,
      S_IDLE,
      S_ARMED,
      S_RUN,
      S_DONE,
      S_ERR
   } state_t;

   state_t            state, state_nxt;
   logic              rx_meta, rx_s;
   logic              rearm_cnt;
   logic [IDLE_W-1:0] idle_cnt;
   logic [CNT_W-1:0]  clk_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic              clk_wrap, idle_full, timed_out;

   assign clk_wrap  = (clk_cnt == CNT_W'(CLKS_PER_BIT-1));
   assign idle_full = (idle_cnt == IDLE_W'(IDLE_LAST));
   assign timed_out = (bit_cnt == BIT_W'(TIMEOUT_BITS));
   assign sd_din    = rx_s;

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx_in;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= S_REARM;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_REARM: if (rearm_cnt) state_nxt = S_IDLE;
         S_IDLE:  if (ctrl_en && rx_s && idle_full) state_nxt = S_ARMED;
         S_ARMED: begin
            if (!ctrl_en)   state_nxt = S_IDLE;
            else if (!rx_s) state_nxt = S_RUN;
         end
         S_RUN: begin
            if (!ctrl_en)         state_nxt = S_REARM;
            else if (sd_complete) state_nxt = S_DONE;
            else if (timed_out)   state_nxt = S_ERR;
         end
         S_DONE:  state_nxt = S_REARM;
         S_ERR:   state_nxt = S_REARM;
         default: state_nxt = S_REARM;
      endcase
   end

   always_comb begin
      armed           = (state == S_ARMED);
      busy            = (state == S_RUN);
      sd_enable       = (state == S_RUN);
      size_valid      = (state == S_DONE);
      timeout_err     = (state == S_ERR);
      sd_resetN       = (state != S_REARM);
      sd_sample_pulse = 1'b0;
      if (state == S_RUN) begin
         if (sd_rate_sel)
            sd_sample_pulse = (clk_cnt == CNT_W'(SAMPLE_PT-2)) ||
                              (clk_cnt == CNT_W'(SAMPLE_PT))   ||
                              (clk_cnt == CNT_W'(SAMPLE_PT+2));
         else
            sd_sample_pulse = (clk_cnt == CNT_W'(SAMPLE_PT));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rearm_cnt   <= 1'b0;
         idle_cnt    <= '0;
         clk_cnt     <= '0;
         bit_cnt     <= '0;
         sd_rate_sel <= 1'b0;
         msg_size    <= '0;
         data_bytes  <= '0;
      end else begin
         rearm_cnt <= (state == S_REARM) ? ~rearm_cnt : 1'b0;

         if (state == S_IDLE && ctrl_en && rx_s) idle_cnt <= idle_cnt + 1'b1;
         else                                    idle_cnt <= '0;

         if (state == S_ARMED && ctrl_en && !rx_s) begin
            clk_cnt     <= '0;
            bit_cnt     <= '0;
            sd_rate_sel <= triple_sample;
         end else if (state == S_RUN) begin
            clk_cnt <= clk_wrap ? '0 : clk_cnt + 1'b1;
            // bit_cnt parks at the timeout value rather than wrapping
            if (clk_wrap && !timed_out) bit_cnt <= bit_cnt + 1'b1;
         end

         if (state == S_RUN && ctrl_en && sd_complete) begin
            msg_size   <= sd_msg_size;
            data_bytes <= (sd_msg_size > 4'd8) ? 4'd8 : sd_msg_size;
         end
      end
   end

endmodule

// File: tb/tb_can_size_sequencer.sv
// Directed self-checking bench for can_size_sequencer with default parameters.
module tb_can_size_sequencer;

   logic       clk = 1'b0;
   logic       reset, ctrl_en, triple_sample, rx_in;
   logic       sd_din, sd_sample_pulse, sd_rate_sel, sd_enable, sd_resetN;
   logic       sd_complete;
   logic [3:0] sd_msg_size;
   logic       armed, busy, size_valid, timeout_err;
   logic [3:0] msg_size, data_bytes;

   int unsigned tests = 0;
   int unsigned fails = 0;

   can_size_sequencer #(
      .CLKS_PER_BIT(50), .SAMPLE_PT(35), .IDLE_BITS(11), .TIMEOUT_BITS(40)
   ) dut (
      .clk(clk), .reset(reset), .ctrl_en(ctrl_en), .triple_sample(triple_sample),
      .rx_in(rx_in), .sd_din(sd_din), .sd_sample_pulse(sd_sample_pulse),
      .sd_rate_sel(sd_rate_sel), .sd_enable(sd_enable), .sd_resetN(sd_resetN),
      .sd_complete(sd_complete), .sd_msg_size(sd_msg_size), .armed(armed),
      .busy(busy), .size_valid(size_valid), .msg_size(msg_size),
      .data_bytes(data_bytes), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic tick(input int unsigned n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_armed();
      int unsigned n = 0;
      while (armed !== 1'b1 && n < 1200) begin
         tick();
         n++;
      end
      check("arm_within_bound", 32'(armed), 32'd1);
   endtask

   // Falling edge on rx_in; RUN starts on the third edge (two sync flops + ARMED decision)
   task automatic sof(input logic triple);
      triple_sample = triple;
      rx_in = 1'b0;
      tick(2);
      check("sof_busy_early", 32'(busy), 32'd0);
      check("sof_din_low", 32'(sd_din), 32'd0);
      rx_in = 1'b1;
      tick();
      check("sof_busy", 32'(busy), 32'd1);
      check("sof_rate_sel", 32'(sd_rate_sel), 32'(triple));
   endtask

   task automatic check_rearm_seq();
      check("rearm0_resetN", 32'(sd_resetN), 32'd0);
      check("rearm0_valid", 32'(size_valid), 32'd0);
      tick();
      check("rearm1_resetN", 32'(sd_resetN), 32'd0);
      tick();
      check("rearm_done_resetN", 32'(sd_resetN), 32'd1);
   endtask

   initial begin
      reset = 1'b1; ctrl_en = 1'b1; triple_sample = 1'b0; rx_in = 1'b1;
      sd_complete = 1'b0; sd_msg_size = 4'h0;
      tick(3);
      check("rst_resetN", 32'(sd_resetN), 32'd0);
      check("rst_outs", {armed, busy, size_valid, timeout_err, sd_enable, sd_sample_pulse},
            32'd0);
      check("rst_sizes", {msg_size, data_bytes}, 32'd0);

      // Idle detection with a glitch at idle clock 300
      reset = 1'b0;
      tick();
      check("rearm_after_rst", 32'(sd_resetN), 32'd0);
      tick();
      check("idle_entered", 32'(sd_resetN), 32'd1);
      tick(300);
      rx_in = 1'b0;
      tick();
      rx_in = 1'b1;
      tick(2);
      check("glitch_not_armed", 32'(armed), 32'd0);
      tick(549);
      check("armed_549", 32'(armed), 32'd0);
      tick();
      check("armed_550", 32'(armed), 32'd1);

      // Single-sample frame: one pulse at clk_cnt 35 of every bit
      sof(1'b0);
      for (int i = 0; i < 100; i++) begin
         check("single_pulse", 32'(sd_sample_pulse), 32'((i % 50) == 35));
         check("single_enable", 32'(sd_enable), 32'd1);
         tick();
      end
      sd_complete = 1'b1; sd_msg_size = 4'hC;
      tick();
      sd_complete = 1'b0;
      check("done_valid", 32'(size_valid), 32'd1);
      check("done_msg_C", 32'(msg_size), 32'hC);
      check("done_bytes_8", 32'(data_bytes), 32'd8);
      check("done_busy", 32'(busy), 32'd0);
      tick();
      check_rearm_seq();

      // Triple-sample frame; mode change mid-frame is ignored
      wait_armed();
      sof(1'b1);
      for (int i = 0; i < 100; i++) begin
         if (i == 10) triple_sample = 1'b0;
         check("triple_pulse", 32'(sd_sample_pulse),
               32'((i % 50) == 33 || (i % 50) == 35 || (i % 50) == 37));
         tick();
      end
      check("triple_rate_held", 32'(sd_rate_sel), 32'd1);
      sd_complete = 1'b1; sd_msg_size = 4'h5;
      tick();
      sd_complete = 1'b0;
      check("done5_valid", 32'(size_valid), 32'd1);
      check("done5_msg", 32'(msg_size), 32'd5);
      check("done5_bytes", 32'(data_bytes), 32'd5);
      tick();
      check_rearm_seq();

      // Timeout with no completion: bit_cnt hits 40 at RUN cycle 2000
      wait_armed();
      sof(1'b0);
      tick(2000);
      check("to_still_busy", 32'(busy), 32'd1);
      check("to_not_yet", 32'(timeout_err), 32'd0);
      tick();
      check("to_pulse", 32'(timeout_err), 32'd1);
      check("to_no_valid", 32'(size_valid), 32'd0);
      check("to_msg_kept", 32'(msg_size), 32'd5);
      tick();
      check("to_one_cycle", 32'(timeout_err), 32'd0);
      check_rearm_seq();

      // Completion coincident with timeout: DONE wins
      wait_armed();
      sof(1'b0);
      tick(2000);
      sd_complete = 1'b1; sd_msg_size = 4'h3;
      tick();
      sd_complete = 1'b0;
      check("coinc_valid", 32'(size_valid), 32'd1);
      check("coinc_no_err", 32'(timeout_err), 32'd0);
      check("coinc_msg", 32'(msg_size), 32'd3);
      check("coinc_bytes", 32'(data_bytes), 32'd3);
      tick();
      check_rearm_seq();

      // Abort via ctrl_en beats a simultaneous completion
      wait_armed();
      sof(1'b0);
      tick(20);
      ctrl_en = 1'b0; sd_complete = 1'b1; sd_msg_size = 4'h9;
      tick();
      sd_complete = 1'b0;
      check("abort_enable", 32'(sd_enable), 32'd0);
      check("abort_valid", 32'(size_valid), 32'd0);
      check("abort_resetN", 32'(sd_resetN), 32'd0);
      check("abort_msg_kept", 32'(msg_size), 32'd3);
      tick(600);
      check("disabled_not_armed", 32'(armed), 32'd0);
      ctrl_en = 1'b1;

      // Reset in the middle of a triple-sample frame
      wait_armed();
      sof(1'b1);
      tick(10);
      reset = 1'b1;
      tick();
      check("midrst_outs", {armed, busy, size_valid, timeout_err, sd_enable, sd_sample_pulse},
            32'd0);
      check("midrst_resetN", 32'(sd_resetN), 32'd0);
      check("midrst_sizes", {msg_size, data_bytes}, 32'd0);
      check("midrst_rate", 32'(sd_rate_sel), 32'd0);
      reset = 1'b0;
      tick(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
